// File: rtl/rollo_support_ctrl.sv
// Sequencer for the ROLLO-I support register file: loads R basis elements, then
// streams N random GF(2)-linear combinations of them downstream.
module rollo_support_ctrl #(
    parameter int unsigned N           = 8,
    parameter int unsigned M           = 8,
    parameter int unsigned R           = 7,
    parameter bit          REJECT_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 sup_valid,
    output logic                 sup_ready,
    input  logic [M-1:0]         sup_data,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [R-1:0]         rnd_data,
    output logic                 rf_rw,
    output logic [R:0]           rf_ctrl_w,
    output logic [$clog2(R)-1:0] rf_addr,
    output logic [M-1:0]         rf_data_in,
    input  logic [M-1:0]         rf_data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx
);

    localparam int unsigned AW = $clog2(R);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [AW-1:0] LdLast  = AW'(R - 1);
    localparam logic [CW-1:0] CntN    = CW'(N);
    localparam logic [CW-1:0] AccLast = CW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StGen,
        StDone
    } state_e;

    state_e         state_q;
    logic [AW-1:0]  ld_cnt_q;
    logic [CW-1:0]  iss_cnt_q;
    logic [CW-1:0]  acc_cnt_q;
    logic           pend_q;
    logic [IW-1:0]  idx_q;
    logic           busy_q;
    logic           done_q;
    logic           out_valid_q;
    logic [M-1:0]   out_data_q;
    logic [IW-1:0]  out_idx_q;

    logic sup_hs;
    logic issue_ok;
    logic rnd_hs;
    logic rnd_zero;
    logic issue;
    logic accept;
    logic last_accept;

    always_comb begin
        sup_hs      = (state_q == StLoad) && sup_valid;
        issue_ok    = (state_q == StGen) && (iss_cnt_q < CntN) && !pend_q &&
                      (!out_valid_q || out_ready);
        rnd_hs      = issue_ok && rnd_valid;
        rnd_zero    = (rnd_data == '0);
        // A zero word selects nothing; with REJECT_ZERO it is swallowed and redrawn.
        issue       = rnd_hs && !(REJECT_ZERO && rnd_zero);
        accept      = out_valid_q && out_ready;
        last_accept = accept && (acc_cnt_q == AccLast);
    end

    always_comb begin
        sup_ready  = (state_q == StLoad);
        rnd_ready  = issue_ok;
        rf_rw      = sup_hs;
        rf_addr    = sup_hs ? ld_cnt_q : '0;
        rf_data_in = sup_hs ? sup_data : '0;
        rf_ctrl_w  = issue ? {1'b1, rnd_data} : '0;
        busy       = busy_q;
        done       = done_q;
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        out_idx    = out_idx_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= StIdle;
            ld_cnt_q    <= '0;
            iss_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            pend_q      <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StLoad;
                        ld_cnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                StLoad: begin
                    if (sup_hs) begin
                        if (ld_cnt_q == LdLast) begin
                            state_q   <= StGen;
                            iss_cnt_q <= '0;
                            acc_cnt_q <= '0;
                            pend_q    <= 1'b0;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + AW'(1);
                        end
                    end
                end
                StGen: begin
                    if (issue) begin
                        pend_q    <= 1'b1;
                        idx_q     <= iss_cnt_q[IW-1:0];
                        iss_cnt_q <= iss_cnt_q + CW'(1);
                    end
                    // rf_data_out is only valid the cycle after an issue.
                    if (pend_q) begin
                        out_data_q  <= rf_data_out;
                        out_idx_q   <= idx_q;
                        out_valid_q <= 1'b1;
                        pend_q      <= 1'b0;
                    end else if (accept) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        acc_cnt_q <= acc_cnt_q + CW'(1);
                        if (last_accept) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rollo_support_ctrl.sv
// Directed bench for rollo_support_ctrl with a behavioural support register file.
module tb_rollo_support_ctrl;

    localparam int N  = 4;
    localparam int M  = 8;
    localparam int R  = 7;
    localparam int AW = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          start;
    logic          busy;
    logic          done;
    logic          sup_valid;
    logic          sup_ready;
    logic [M-1:0]  sup_data;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [R-1:0]  rnd_data;
    logic          rf_rw;
    logic [R:0]    rf_ctrl_w;
    logic [AW-1:0] rf_addr;
    logic [M-1:0]  rf_data_in;
    logic [M-1:0]  rf_data_out;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_data;
    logic [IW-1:0] out_idx;

    rollo_support_ctrl #(
        .N(N), .M(M), .R(R), .REJECT_ZERO(1'b1)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .sup_valid  (sup_valid),
        .sup_ready  (sup_ready),
        .sup_data   (sup_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .rf_rw      (rf_rw),
        .rf_ctrl_w  (rf_ctrl_w),
        .rf_addr    (rf_addr),
        .rf_data_in (rf_data_in),
        .rf_data_out(rf_data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: element j is selected by select bit R-1-j.
    logic [M-1:0] files [R];

    function automatic logic [M-1:0] combine(input logic [R-1:0] sel);
        logic [M-1:0] acc = '0;
        for (int j = 0; j < R; j++) if (sel[R-1-j]) acc ^= files[j];
        return acc;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int j = 0; j < R; j++) files[j] <= '0;
            rf_data_out <= '0;
        end else begin
            if (rf_rw) files[rf_addr] <= rf_data_in;
            if (rf_ctrl_w[R]) rf_data_out <= combine(rf_ctrl_w[R-1:0]);
            else              rf_data_out <= files[rf_addr];
        end
    end

    // Event logs, sampled mid-cycle.
    int           wr_addr_q [$];
    logic [M-1:0] wr_data_q [$];
    int           iss_cyc_q [$];
    logic [M-1:0] acc_data_q [$];
    int           acc_idx_q [$];
    int           rnd_cons = 0;
    int           done_cnt = 0;
    int           busy_at_done = 0;

    always @(negedge clk) begin
        if (rf_rw) begin
            wr_addr_q.push_back(int'(rf_addr));
            wr_data_q.push_back(rf_data_in);
        end
        if (rf_ctrl_w[R]) iss_cyc_q.push_back(cyc);
        if (rnd_valid && rnd_ready) rnd_cons++;
        if (out_valid && out_ready) begin
            acc_data_q.push_back(out_data);
            acc_idx_q.push_back(int'(out_idx));
        end
        if (done) begin
            done_cnt++;
            if (busy) busy_at_done++;
        end
    end

    int checks = 0;
    int passed = 0;

    logic [M-1:0] sup_vals [R];
    logic [M-1:0] exp_data [N];
    logic [R-1:0] rnd_list [$];
    int           ri = 0;

    logic          s_out_valid;
    logic [M-1:0]  s_out_data;
    logic [IW-1:0] s_out_idx;
    logic          s_rnd_ready;

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_all(input bit stall, input int start_at);
        int k = 0;
        int guard = 0;
        bit hs;
        while (k < R && guard < 200) begin
            sup_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            sup_data  = sup_vals[k];
            start     = (k == start_at);
            @(negedge clk);
            hs = sup_valid && sup_ready;
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
        end
        sup_valid = 1'b0;
        sup_data  = '0;
        start     = 1'b0;
        checks++;
        if (k != R) $display("FAIL load_timeout: loaded %0d elements, required %0d", k, R);
        else passed++;
    endtask

    task automatic gen_cycle(input bit rv, input bit ordy);
        bit hs;
        rnd_valid = rv && (ri < rnd_list.size());
        rnd_data  = (ri < rnd_list.size()) ? rnd_list[ri] : '0;
        out_ready = ordy;
        @(negedge clk);
        s_out_valid = out_valid;
        s_out_data  = out_data;
        s_out_idx   = out_idx;
        s_rnd_ready = rnd_ready;
        hs = rnd_valid && rnd_ready;
        @(posedge clk); #1;
        if (hs) ri++;
    endtask

    task automatic gen_until_done(input bit stall);
        int db = done_cnt;
        int guard = 0;
        while (done_cnt == db && guard < 300) begin
            gen_cycle(stall ? ($urandom_range(0, 1) == 1) : 1'b1,
                      stall ? ($urandom_range(0, 1) == 1) : 1'b1);
            guard++;
        end
        rnd_valid = 1'b0;
        rnd_data  = '0;
        out_ready = 1'b0;
        checks++;
        if (done_cnt == db) $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, db + 1);
        else passed++;
    endtask

    task automatic test_reset();
        logic [40:0] all_out;
        rst_b = 1'b1;
        #2 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_out = {busy, done, sup_ready, rnd_ready, rf_rw, rf_ctrl_w, rf_addr, rf_data_in,
                   out_valid, out_data, out_idx};
        checks++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h, required 0", all_out);
        else passed++;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, sup_ready, rf_rw} !== 3'b000)
            $display("FAIL idle_no_start: busy/sup_ready/rf_rw %b, required 000", {busy, sup_ready, rf_rw});
        else passed++;
    endtask

    task automatic test_basic();
        int wb = wr_addr_q.size();
        int ab = acc_data_q.size();
        int ib = iss_cyc_q.size();
        int db = done_cnt;
        int bb = busy_at_done;
        int min_gap = 1000;
        sup_vals = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64};
        rnd_list = '{7'h41, 7'h7F, 7'h40, 7'h01};
        exp_data = '{8'd65, 8'd127, 8'd1, 8'd64};
        ri = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy: busy %b, required 1", busy);
        else passed++;
        load_all(1'b0, -1);
        gen_until_done(1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < R; k++) begin
            checks++;
            if (wb + k >= wr_addr_q.size())
                $display("FAIL basic_write%0d: missing, required addr %0d data %0d", k, k, sup_vals[k]);
            else if (wr_addr_q[wb+k] != k || wr_data_q[wb+k] !== sup_vals[k])
                $display("FAIL basic_write%0d: addr %0d data %0d, required addr %0d data %0d",
                         k, wr_addr_q[wb+k], wr_data_q[wb+k], k, sup_vals[k]);
            else passed++;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ab + i >= acc_data_q.size())
                $display("FAIL basic_out%0d: missing, required data %0d idx %0d", i, exp_data[i], i);
            else if (acc_data_q[ab+i] !== exp_data[i] || acc_idx_q[ab+i] != i)
                $display("FAIL basic_out%0d: data %0d idx %0d, required data %0d idx %0d",
                         i, acc_data_q[ab+i], acc_idx_q[ab+i], exp_data[i], i);
            else passed++;
        end
        for (int i = ib + 1; i < iss_cyc_q.size(); i++)
            if (iss_cyc_q[i] - iss_cyc_q[i-1] < min_gap) min_gap = iss_cyc_q[i] - iss_cyc_q[i-1];
        checks++;
        if (iss_cyc_q.size() - ib != N || min_gap < 2)
            $display("FAIL basic_issues: count %0d min gap %0d, required count %0d gap >= 2",
                     iss_cyc_q.size() - ib, min_gap, N);
        else passed++;
        checks++;
        if (done_cnt != db + 1 || busy_at_done != bb)
            $display("FAIL basic_done: pulses %0d busy-at-done %0d, required 1 and 0",
                     done_cnt - db, busy_at_done - bb);
        else passed++;
    endtask

    task automatic test_reject_zero();
        int ab = acc_data_q.size();
        int ib = iss_cyc_q.size();
        int rb = rnd_cons;
        sup_vals = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64};
        rnd_list = '{7'h00, 7'h00, 7'h01, 7'h02, 7'h04, 7'h08};
        exp_data = '{8'd64, 8'd32, 8'd16, 8'd8};
        ri = 0;
        pulse_start();
        load_all(1'b0, -1);
        gen_until_done(1'b0);
        checks++;
        if (rnd_cons - rb != 6 || iss_cyc_q.size() - ib != N)
            $display("FAIL reject_counts: consumed %0d issued %0d, required 6 and %0d",
                     rnd_cons - rb, iss_cyc_q.size() - ib, N);
        else passed++;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ab + i >= acc_data_q.size())
                $display("FAIL reject_out%0d: missing, required data %0d idx %0d", i, exp_data[i], i);
            else if (acc_data_q[ab+i] !== exp_data[i] || acc_idx_q[ab+i] != i)
                $display("FAIL reject_out%0d: data %0d idx %0d, required data %0d idx %0d",
                         i, acc_data_q[ab+i], acc_idx_q[ab+i], exp_data[i], i);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int ab = acc_data_q.size();
        int ib;
        int guard = 0;
        bit stable = 1'b1;
        sup_vals = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64};
        rnd_list = '{7'h03, 7'h10, 7'h20, 7'h7E};
        exp_data = '{8'd96, 8'd4, 8'd2, 8'd63};
        ri = 0;
        pulse_start();
        load_all(1'b0, -1);
        s_out_valid = 1'b0;
        while (!s_out_valid && guard < 20) begin
            gen_cycle(1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 8'd96 || s_out_idx !== 2'd0)
            $display("FAIL bp_first: valid %b data %0d idx %0d, required 1 96 0",
                     s_out_valid, s_out_data, s_out_idx);
        else passed++;
        ib = iss_cyc_q.size();
        for (int c = 0; c < 10; c++) begin
            gen_cycle(1'b1, 1'b0);
            if (s_out_valid !== 1'b1 || s_out_data !== 8'd96 || s_rnd_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable || iss_cyc_q.size() != ib)
            $display("FAIL bp_hold: stable %b new issues %0d, required 1 and 0",
                     stable, iss_cyc_q.size() - ib);
        else passed++;
        gen_until_done(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ab + i >= acc_data_q.size())
                $display("FAIL bp_out%0d: missing, required data %0d idx %0d", i, exp_data[i], i);
            else if (acc_data_q[ab+i] !== exp_data[i] || acc_idx_q[ab+i] != i)
                $display("FAIL bp_out%0d: data %0d idx %0d, required data %0d idx %0d",
                         i, acc_data_q[ab+i], acc_idx_q[ab+i], exp_data[i], i);
            else passed++;
        end
    endtask

    task automatic test_stall_full_run();
        int wb = wr_addr_q.size();
        int ab = acc_data_q.size();
        int db = done_cnt;
        int bb = busy_at_done;
        sup_vals = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h0F, 8'hF0, 8'h3C};
        rnd_list = '{7'h55, 7'h2A, 7'h0F, 7'h70};
        exp_data = '{8'h66, 8'h5A, 8'h4B, 8'h77};
        ri = 0;
        pulse_start();
        load_all(1'b1, -1);
        gen_until_done(1'b1);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < R; k++) begin
            checks++;
            if (wb + k >= wr_addr_q.size())
                $display("FAIL stall_write%0d: missing, required addr %0d data %h", k, k, sup_vals[k]);
            else if (wr_addr_q[wb+k] != k || wr_data_q[wb+k] !== sup_vals[k])
                $display("FAIL stall_write%0d: addr %0d data %h, required addr %0d data %h",
                         k, wr_addr_q[wb+k], wr_data_q[wb+k], k, sup_vals[k]);
            else passed++;
        end
        checks++;
        if (acc_data_q.size() - ab != N)
            $display("FAIL stall_count: accepted %0d, required %0d", acc_data_q.size() - ab, N);
        else passed++;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ab + i >= acc_data_q.size())
                $display("FAIL stall_out%0d: missing, required data %h idx %0d", i, exp_data[i], i);
            else if (acc_data_q[ab+i] !== exp_data[i] || acc_idx_q[ab+i] != i)
                $display("FAIL stall_out%0d: data %h idx %0d, required data %h idx %0d",
                         i, acc_data_q[ab+i], acc_idx_q[ab+i], exp_data[i], i);
            else passed++;
        end
        checks++;
        if (done_cnt != db + 1 || busy_at_done != bb || busy !== 1'b0)
            $display("FAIL stall_done: pulses %0d busy-at-done %0d busy %b, required 1 0 0",
                     done_cnt - db, busy_at_done - bb, busy);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [40:0] all_out;
        int db = done_cnt;
        int guard = 0;
        sup_vals = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64};
        rnd_list = '{7'h41, 7'h7F, 7'h40, 7'h01};
        ri = 0;
        pulse_start();
        load_all(1'b0, -1);
        s_out_valid = 1'b0;
        while (!s_out_valid && guard < 20) begin
            gen_cycle(1'b1, 1'b0);
            guard++;
        end
        checks++;
        if (s_out_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL rst_pre: valid %b busy %b, required 1 1", s_out_valid, busy);
        else passed++;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        all_out = {busy, done, sup_ready, rnd_ready, rf_rw, rf_ctrl_w, rf_addr, rf_data_in,
                   out_valid, out_data, out_idx};
        checks++;
        if (all_out !== '0) $display("FAIL rst_async: got %h, required 0", all_out);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != db || busy !== 1'b0)
            $display("FAIL rst_no_done: done pulses %0d busy %b, required 0 0", done_cnt - db, busy);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int wb = wr_addr_q.size();
        int ab = acc_data_q.size();
        int db = done_cnt;
        sup_vals = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64};
        rnd_list = '{7'h41, 7'h7F, 7'h40, 7'h01};
        exp_data = '{8'd65, 8'd127, 8'd1, 8'd64};
        ri = 0;
        pulse_start();
        load_all(1'b0, 2);
        gen_until_done(1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < R; k++) begin
            checks++;
            if (wb + k >= wr_addr_q.size())
                $display("FAIL rerun_write%0d: missing, required addr %0d", k, k);
            else if (wr_addr_q[wb+k] != k || wr_data_q[wb+k] !== sup_vals[k])
                $display("FAIL rerun_write%0d: addr %0d data %0d, required addr %0d data %0d",
                         k, wr_addr_q[wb+k], wr_data_q[wb+k], k, sup_vals[k]);
            else passed++;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ab + i >= acc_data_q.size())
                $display("FAIL rerun_out%0d: missing, required data %0d idx %0d", i, exp_data[i], i);
            else if (acc_data_q[ab+i] !== exp_data[i] || acc_idx_q[ab+i] != i)
                $display("FAIL rerun_out%0d: data %0d idx %0d, required data %0d idx %0d",
                         i, acc_data_q[ab+i], acc_idx_q[ab+i], exp_data[i], i);
            else passed++;
        end
        checks++;
        if (done_cnt != db + 1) $display("FAIL rerun_done: pulses %0d, required 1", done_cnt - db);
        else passed++;
    endtask

    initial begin
        start     = 1'b0;
        sup_valid = 1'b0;
        sup_data  = '0;
        rnd_valid = 1'b0;
        rnd_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_reject_zero();
        test_backpressure();
        test_stall_full_run();
        test_reset_mid_run();
        test_start_ignored();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
